// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single-port synchronous instruction memory between the program
//   loader (write port) and the CPU fetch unit (read port). One access per
//   cycle; the loader wins by default, but a fetch that has lost MAX_WAIT
//   consecutive cycles is forced through.
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   W, OVERWRITE, ADDR, DATA_WR      loader request / qualifier / address / data
//   wr_ack, wr_rej, wr_count         loader status and accepted-write counter
//   fetch_req, fetch_addr            CPU read request / address
//   fetch_stall, fetch_valid,
//   fetch_data                       CPU read status and returned word
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             memory macro interface
//
// State (register r_last, previous cycle's grant)
//   state | meaning
//   IDLE  | no access granted last cycle
//   READ  | fetch granted last cycle; mem_rdata holds its word now
//   WRITE | loader write granted last cycle

module imem_port_arbiter #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 5,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 W,
  input  logic                 OVERWRITE,
  input  logic [ADDR_SIZE-1:0] ADDR,
  input  logic [DATA_SIZE-1:0] DATA_WR,
  output logic                 wr_ack,
  output logic                 wr_rej,
  output logic [ADDR_SIZE:0]   wr_count,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_stall,
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] fetch_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] C_WAIT_ONE = WAIT_W'(1);
  localparam logic [ADDR_SIZE:0] C_CNT_ONE = (ADDR_SIZE + 1)'(1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              r_last;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [ADDR_SIZE:0]  r_wr_count;

  logic w_wr_req;
  logic w_force_fetch;
  logic w_fetch_grant;
  logic w_wr_grant;

  // Grants are qualified with rstn so every output is quiet while in reset.
  assign w_wr_req      = W & OVERWRITE;
  assign w_force_fetch = (r_wait_cnt == C_WAIT_MAX);
  assign w_fetch_grant = rstn & fetch_req & (~w_wr_req | w_force_fetch);
  assign w_wr_grant    = rstn & w_wr_req & ~w_fetch_grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last     <= IDLE;
      r_wait_cnt <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_fetch_grant)   r_last <= READ;
      else if (w_wr_grant) r_last <= WRITE;
      else                 r_last <= IDLE;

      // Counts consecutive cycles a pending fetch has lost to the loader.
      if (w_fetch_grant || !fetch_req)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != C_WAIT_MAX)
        r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;

      if (w_wr_grant && (r_wr_count != '1))
        r_wr_count <= r_wr_count + C_CNT_ONE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (w_wr_grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR;
      mem_wdata = DATA_WR;
      wr_ack    = 1'b1;
    end else if (w_fetch_grant) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end
  end

  assign wr_rej      = rstn & W & ~OVERWRITE;
  assign fetch_stall = rstn & fetch_req & ~w_fetch_grant;
  assign fetch_valid = rstn & (r_last == READ);
  assign fetch_data  = fetch_valid ? mem_rdata : '0;
  assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int MAXW = 4;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          W, OVERWRITE;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DATA_WR;
  logic          wr_ack, wr_rej;
  logic [AW:0]   wr_count;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall, fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  imem_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rstn(rstn), .W(W), .OVERWRITE(OVERWRITE), .ADDR(ADDR),
    .DATA_WR(DATA_WR), .wr_ack(wr_ack), .wr_rej(wr_rej), .wr_count(wr_count),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: synchronous single port, read data one cycle after strobe.
  logic [DW-1:0] mem_arr [32] = '{default: 16'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  // Reference model: contents as the loader intends them, a count of
  // consecutive losses for the pending fetch, and the word owed to the CPU.
  int          ref_mem [32];
  int          m_wait;
  int          m_count;
  bit          m_pending;
  int          m_rdata;

  task automatic model_reset();
    m_wait = 0; m_count = 0; m_pending = 0; m_rdata = 0;
  endtask

  task automatic predict(output bit fg, output bit wg);
    bit wr;
    wr = W && OVERWRITE;
    fg = rstn && fetch_req && (!wr || m_wait >= MAXW);
    wg = rstn && wr && !fg;
  endtask

  // Advance one clock (caller sits just after a negedge) and update the model.
  task automatic step();
    bit fg, wg, freq;
    int a, fa, d;
    predict(fg, wg);
    a = int'(ADDR); fa = int'(fetch_addr); d = int'(DATA_WR); freq = fetch_req;
    @(posedge clk);
    if (!rstn) model_reset();
    else begin
      if (wg) begin
        ref_mem[a] = d;
        if (m_count < CNT_MAX) m_count++;
      end
      m_pending = fg;
      if (fg) m_rdata = ref_mem[fa];
      if (fg || !freq) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    W = 0; OVERWRITE = 0; ADDR = '0; DATA_WR = '0; fetch_req = 0; fetch_addr = '0;
  endtask

  task automatic test_reset();
    rstn = 0;
    W = 1; OVERWRITE = 1; ADDR = 5'd7; DATA_WR = 16'hBEEF;
    fetch_req = 1; fetch_addr = 5'd3;
    #1;
    n_checks++;
    if ({wr_ack, wr_rej, fetch_stall, fetch_valid, mem_en, mem_we} !== 6'b0 ||
        wr_count !== '0 || fetch_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ack=%b rej=%b stall=%b valid=%b en=%b we=%b cnt=%0d addr=%0d wdata=%h fdata=%h required all 0",
               wr_ack, wr_rej, fetch_stall, fetch_valid, mem_en, mem_we, wr_count, mem_addr, mem_wdata, fetch_data);
    end
    @(negedge clk);
    idle_inputs();
    rstn = 1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [DW-1:0] words [3];
    words[0] = 16'h1021; words[1] = 16'h4032; words[2] = 16'h6010;
    for (int i = 0; i < 3; i++) begin
      W = 1; OVERWRITE = 1; ADDR = AW'(i); DATA_WR = words[i]; fetch_req = 0;
      #1;
      n_checks++;
      if (wr_ack !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
          mem_addr !== AW'(i) || mem_wdata !== words[i]) begin
        n_errors++;
        $display("FAIL load_write%0d: ack=%b en=%b we=%b addr=%0d wdata=%h required 1 1 1 %0d %h",
                 i, wr_ack, mem_en, mem_we, mem_addr, mem_wdata, i, words[i]);
      end
      step();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (wr_count !== 6'd3) begin
      n_errors++;
      $display("FAIL load_count: got %0d required 3", wr_count);
    end
  endtask

  task automatic test_rejected();
    W = 1; OVERWRITE = 0; ADDR = 5'd5; DATA_WR = 16'hDEAD; fetch_req = 0;
    #1;
    n_checks++;
    if (wr_rej !== 1'b1 || mem_en !== 1'b0 || wr_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reject: rej=%b en=%b ack=%b required 1 0 0", wr_rej, mem_en, wr_ack);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (wr_count !== 6'd3) begin
      n_errors++;
      $display("FAIL reject_count: got %0d required 3", wr_count);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] words [3];
    words[0] = 16'h1021; words[1] = 16'h4032; words[2] = 16'h6010;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i < 3) begin fetch_req = 1; fetch_addr = AW'(i); end
      #1;
      n_checks++;
      if (fetch_stall !== 1'b0 || (i < 3 && (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(i)))) begin
        n_errors++;
        $display("FAIL stream_grant%0d: stall=%b en=%b we=%b addr=%0d required 0 1 0 %0d",
                 i, fetch_stall, mem_en, mem_we, mem_addr, i);
      end
      if (i > 0) begin
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== words[i-1]) begin
          n_errors++;
          $display("FAIL stream_data%0d: valid=%b data=%h required 1 %h", i, fetch_valid, fetch_data, words[i-1]);
        end
      end
      step();
    end
    #1;
    n_checks++;
    if (fetch_valid !== 1'b0 || fetch_data !== '0) begin
      n_errors++;
      $display("FAIL stream_end: valid=%b data=%h required 0 0000", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_starvation();
    int exp_cnt;
    fetch_req = 1; fetch_addr = 5'd0; W = 1; OVERWRITE = 1;
    for (int i = 0; i < 6; i++) begin
      ADDR = AW'(8 + i); DATA_WR = DW'($urandom);
      #1;
      if (i < 4 || i == 5) begin
        n_checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || fetch_stall !== 1'b1) begin
          n_errors++;
          $display("FAIL starve_write%0d: ack=%b we=%b stall=%b required 1 1 1", i, wr_ack, mem_we, fetch_stall);
        end
      end else begin
        n_checks++;
        if (wr_ack !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || fetch_stall !== 1'b0 || mem_addr !== 5'd0) begin
          n_errors++;
          $display("FAIL starve_force: ack=%b en=%b we=%b stall=%b addr=%0d required 0 1 0 0 0",
                   wr_ack, mem_en, mem_we, fetch_stall, mem_addr);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_data !== 16'h1021) begin
          n_errors++;
          $display("FAIL starve_data: valid=%b data=%h required 1 1021", fetch_valid, fetch_data);
        end
      end
      step();
    end
    idle_inputs();
    #1;
    exp_cnt = 3 + 5;
    n_checks++;
    if (int'(wr_count) != exp_cnt) begin
      n_errors++;
      $display("FAIL starve_count: got %0d required %0d", wr_count, exp_cnt);
    end
  endtask

  task automatic test_mid_read_reset();
    idle_inputs();
    fetch_req = 1; fetch_addr = 5'd1;
    step();
    #1;
    n_checks++;
    if (fetch_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_pre: valid=%b required 1", fetch_valid);
    end
    W = 1; OVERWRITE = 1; ADDR = 5'd9; DATA_WR = 16'h5555;
    rstn = 0;
    model_reset();
    #1;
    n_checks++;
    if ({wr_ack, wr_rej, fetch_stall, fetch_valid, mem_en, mem_we} !== 6'b0 ||
        wr_count !== '0 || fetch_data !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: ack=%b rej=%b stall=%b valid=%b en=%b we=%b cnt=%0d fdata=%h required all 0",
               wr_ack, wr_rej, fetch_stall, fetch_valid, mem_en, mem_we, wr_count, fetch_data);
    end
    @(negedge clk);
    idle_inputs();
    rstn = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (fetch_valid !== 1'b0 || wr_count !== '0) begin
      n_errors++;
      $display("FAIL midreset_after: valid=%b cnt=%0d required 0 0", fetch_valid, wr_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 70; i++) begin
      W = 1; OVERWRITE = 1; ADDR = AW'($urandom); DATA_WR = DW'($urandom); fetch_req = 0;
      step();
      if (i == 62 || i == 63 || i == 70) begin
        #1;
        n_checks++;
        if (int'(wr_count) != ((i < CNT_MAX) ? i : CNT_MAX)) begin
          n_errors++;
          $display("FAIL saturate_%0d: got %0d required %0d", i, wr_count, (i < CNT_MAX) ? i : CNT_MAX);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit fg, wg, hold;
    bit e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      W = ($urandom_range(0, 3) != 0);
      OVERWRITE = ($urandom_range(0, 4) != 0);
      ADDR = AW'($urandom); DATA_WR = DW'($urandom);
      if (!hold) begin
        fetch_req = ($urandom_range(0, 2) != 0);
        fetch_addr = AW'($urandom);
      end
      #1;
      predict(fg, wg);
      e_en = fg || wg; e_we = wg;
      e_addr = wg ? ADDR : (fg ? fetch_addr : '0);
      e_wdata = wg ? DATA_WR : '0;
      n_checks++;
      if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr ||
          wr_ack !== wg || fetch_stall !== (fetch_req && !fg) || wr_rej !== (W && !OVERWRITE)) begin
        n_errors++;
        $display("FAIL rand_ctrl%0d: en=%b we=%b addr=%0d ack=%b stall=%b rej=%b required %b %b %0d %b %b %b",
                 i, mem_en, mem_we, mem_addr, wr_ack, fetch_stall, wr_rej,
                 e_en, e_we, e_addr, wg, fetch_req && !fg, W && !OVERWRITE);
      end
      n_checks++;
      if ((wg && mem_wdata !== e_wdata) || (!e_en && mem_wdata !== '0)) begin
        n_errors++;
        $display("FAIL rand_wdata%0d: got %h required %h", i, mem_wdata, e_wdata);
      end
      n_checks++;
      if (fetch_valid !== m_pending || fetch_data !== (m_pending ? DW'(m_rdata) : DW'(0)) ||
          int'(wr_count) != m_count) begin
        n_errors++;
        $display("FAIL rand_resp%0d: valid=%b data=%h cnt=%0d required %b %h %0d",
                 i, fetch_valid, fetch_data, wr_count, m_pending, m_pending ? DW'(m_rdata) : DW'(0), m_count);
      end
      hold = fetch_req && !fg;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 0;
    model_reset();
    idle_inputs();
    rstn = 0;
    @(negedge clk);
    test_reset();
    test_load();
    test_rejected();
    test_streaming();
    test_starvation();
    test_mid_read_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequences and shares the single-port, synchronous instruction memory of the Salamander-4 core between two requesters. The external program loader uses the `W`/`OVERWRITE`/`ADDR`/`DATA_WR` bus. The CPU fetch unit reads the memory as instructions, each word laid out as `{op_code, mem_op, left_operand, right_operand}`. The block sits between `top_level`'s loader pins, the fetch stage and the memory macro. It grants exactly one access per cycle and stalls the losing requester. It also guarantees fetch forward progress during long loads.

## Interface
- `DATA_SIZE`, default 16: instruction word width.
- `ADDR_SIZE`, default 5: memory address width (32 words).
- `MAX_WAIT`, default 4: maximum consecutive cycles a pending fetch can lose to the loader.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `W`  in  1  loader write request.
- `OVERWRITE`  in  1  loader write enable qualifier; a write is legal only when `W && OVERWRITE`.
- `ADDR`  in  ADDR_SIZE  loader write address.
- `DATA_WR`  in  DATA_SIZE  loader write data.
- `wr_ack`  out  1  loader write performed this cycle.
- `wr_rej`  out  1  `W` is high and `OVERWRITE` is low this cycle; no memory access is made.
- `wr_count`  out  ADDR_SIZE+1  accepted writes since reset; saturates at all-ones.
- `fetch_req`  in  1  CPU read request; held until granted.
- `fetch_addr`  in  ADDR_SIZE  CPU read address.
- `fetch_stall`  out  1  `fetch_req && !fetch_grant`.
- `fetch_valid`  out  1  `fetch_data` is valid.
- `fetch_data`  out  DATA_SIZE  read word.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_SIZE  memory address.
- `mem_wdata`  out  DATA_SIZE  memory write data.
- `mem_rdata`  in  DATA_SIZE  memory read data, valid one cycle after a read strobe.

## Operation
- Requests each cycle:
  - `wr_req = W && OVERWRITE`.
  - `force_fetch = (wait_cnt == MAX_WAIT)`.
- Grant:
  - `fetch_grant = fetch_req && (!wr_req || force_fetch)`.
  - `wr_grant = wr_req && !fetch_grant`.
- The loader wins by default. Fetch wins when there is no write, or when the starvation limit is hit.
- Memory drive:
  - On a write grant: `mem_en=1`, `mem_we=1`, `mem_addr=ADDR`, `mem_wdata=DATA_WR`, `wr_ack=1`.
  - On a fetch grant: `mem_en=1`, `mem_we=0`, `mem_addr=fetch_addr`.
  - Otherwise: `mem_en=0`, `mem_we=0`, and `mem_addr`/`mem_wdata` are driven to 0.
- FSM (register `last`, records the previous cycle's grant):
  - IDLE: no grant.
  - READ: fetch granted.
  - WRITE: write granted.
  - Next state is set by this cycle's grant.
  - `fetch_valid = (last == READ)`; `fetch_data = mem_rdata` when `fetch_valid`, else 0.
- `wait_cnt` (width `$clog2(MAX_WAIT+1)`):
  - Cleared when `fetch_grant` or `!fetch_req`.
  - Otherwise incremented, never exceeding MAX_WAIT.
- `wr_count` increments on each `wr_grant` and saturates at `2^(ADDR_SIZE+1)-1`.
- `wr_rej` has no side effects. It does not change `wait_cnt` and does not touch memory.
- Same-cycle `wr_req` and `fetch_req` to the same address: only one is granted, so there is no hazard. A fetch granted after a write to the same address returns the new data.

## Timing
- Grant decisions and memory outputs are combinational from the inputs plus state. `wr_ack`, `wr_rej` and `fetch_stall` are the same cycle.
- Read latency: grant in cycle t produces `fetch_valid` in cycle t+1.
- Back-to-back fetches are allowed: one read per cycle, with `fetch_valid` high continuously.
- Reset values:
  - `last=IDLE`, `wait_cnt=0`, `wr_count=0`.
  - Every output is 0 while `rstn=0`, including the combinational outputs.
- Reset asserted mid-read drops the outstanding read: `fetch_valid=0` on the next cycle.
- Worst-case fetch latency under continuous writes is MAX_WAIT stalled cycles, then a grant.

## Test plan
- Load: assert reset, then write 0x1021 at address 0, 0x4032 at address 1 and 0x6010 at address 2 with `W=OVERWRITE=1` and no fetches. Expect `wr_ack` each cycle, `mem_we=1`, and `wr_count=3` afterwards.
- Rejected write: `W=1`, `OVERWRITE=0`, `ADDR=5`. Expect `wr_rej=1`, `mem_en=0`, and `wr_count` unchanged.
- Streaming fetch: `fetch_req` held high on addresses 0, 1, 2 in consecutive cycles after the load. Expect `fetch_valid` on cycles t+1..t+3 with data 0x1021, 0x4032, 0x6010, and `fetch_stall=0`.
- Starvation: continuous writes with `fetch_req=1` at address 0 and `MAX_WAIT=4`. Expect 4 write grants with `fetch_stall=1`, then a fetch grant in the 5th cycle with `wr_ack=0`, then writes resume.
- Mid-read reset: grant a fetch, then pull `rstn` low in the next cycle. Expect `fetch_valid=0`, all outputs 0, and `wr_count=0`.
- Saturation: perform 70 accepted writes with ADDR_SIZE=5. Expect `wr_count` to stop at 63.
